id_stage_pipe: RTL and testbench

Parametrised pipelined instruction-decode stage for the LEGv8 core. It sits between IF and EX, and contains:
- the register file, with write-back bypass;
- format-aware immediate extension;
- load-use hazard detection;
- the ID/EX pipeline register with a valid/ready handshake and flush.

It supersedes the single-cycle ID block, which had no pipeline register, no backpressure and no hazard logic.

---
 rtl/legv8_pkg.sv | 45 ++++
 rtl/id_stage_pipe_if.sv | 42 ++++
 rtl/id_regfile.sv | 39 +++
 rtl/id_stage_pipe.sv | 115 +++++++++++
 tb/tb_id_stage_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: instruction formats, opcode constants and
// the format classifier used by the ID stage.
package legv8_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_D_LD = 3'd2,
      FMT_D_ST = 3'd3,
      FMT_CB   = 3'd4,
      FMT_B    = 3'd5
   } fmt_e;

   localparam logic [4:0]  XZR_IDX  = 5'd31;

   localparam logic [5:0]  OP_B     = 6'h05;
   localparam logic [7:0]  OP_CBZ   = 8'hB4;
   localparam logic [7:0]  OP_CBNZ  = 8'hB5;
   localparam logic [10:0] OP_STUR  = 11'h7C0;
   localparam logic [10:0] OP_LDUR  = 11'h7C2;
   localparam logic [9:0]  OP_ADDI  = 10'h244;
   localparam logic [9:0]  OP_SUBI  = 10'h344;
   localparam logic [9:0]  OP_ANDI  = 10'h248;
   localparam logic [9:0]  OP_ORRI  = 10'h2C8;

   // op is inst[31:21]; the narrower opcode fields are its upper slices.
   // Tests are ordered so the first match wins.
   function automatic fmt_e classify(input logic [10:0] op);
      if (op[10:5] == OP_B)                                  return FMT_B;
      if (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ)         return FMT_CB;
      if (op == OP_STUR)                                     return FMT_D_ST;
      if (op == OP_LDUR)                                     return FMT_D_LD;
      if (op[10:1] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI}) return FMT_I;
      return FMT_R;
   endfunction

   function automatic logic uses_rn(input fmt_e f);
      return f inside {FMT_R, FMT_D_ST, FMT_I, FMT_D_LD};
   endfunction

   function automatic logic uses_rm(input fmt_e f);
      return f inside {FMT_R, FMT_D_ST, FMT_CB};
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF -> ID -> EX handshake bundle plus the write-back port of the ID stage.
// slave is the ID stage side, master is the surrounding pipeline.
interface id_stage_pipe_if
   import legv8_pkg::*;
#(
   parameter int WORD      = 64,
   parameter int INST_SIZE = 32
);
   logic                 if_valid;
   logic [INST_SIZE-1:0] if_inst;
   logic [WORD-1:0]      if_pc;
   logic                 id_ready;

   logic                 wb_en;
   logic [4:0]           wb_reg;
   logic [WORD-1:0]      wb_data;

   logic                 flush;
   logic                 ex_ready;
   logic                 ex_valid;
   logic [WORD-1:0]      ex_r_data1;
   logic [WORD-1:0]      ex_r_data2;
   logic [WORD-1:0]      ex_ex_data;
   logic [4:0]           ex_rd;
   logic [4:0]           ex_rn;
   logic [4:0]           ex_rm;
   fmt_e                 ex_fmt;
   logic [WORD-1:0]      ex_pc;

   modport slave (
      input  if_valid, if_inst, if_pc, wb_en, wb_reg, wb_data, flush, ex_ready,
      output id_ready, ex_valid, ex_r_data1, ex_r_data2, ex_ex_data,
             ex_rd, ex_rn, ex_rm, ex_fmt, ex_pc
   );

   modport master (
      output if_valid, if_inst, if_pc, wb_en, wb_reg, wb_data, flush, ex_ready,
      input  id_ready, ex_valid, ex_r_data1, ex_r_data2, ex_ex_data,
             ex_rd, ex_rn, ex_rm, ex_fmt, ex_pc
   );

endinterface

// File: rtl/id_regfile.sv
// Two-read, one-write register file; XZR reads as zero, and a write in flight
// is bypassed to a read of the same register in the same cycle.
module id_regfile
   import legv8_pkg::*;
#(
   parameter int WORD     = 64,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_en,
   input  logic [4:0]      wb_reg,
   input  logic [WORD-1:0] wb_data,
   input  logic [4:0]      rd_idx1,
   input  logic [4:0]      rd_idx2,
   output logic [WORD-1:0] rd_data1,
   output logic [WORD-1:0] rd_data2
);

   logic [WORD-1:0] regs [NUM_REGS];

   // NOTE: the array is cleared by reset because a reset must make every
   // register read back as zero; this forces flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_reg != XZR_IDX) begin
         regs[wb_reg] <= wb_data;
      end
   end

   assign rd_data1 = (rd_idx1 == XZR_IDX)                ? '0      :
                     (wb_en && wb_reg == rd_idx1)        ? wb_data :
                                                           regs[rd_idx1];
   assign rd_data2 = (rd_idx2 == XZR_IDX)                ? '0      :
                     (wb_en && wb_reg == rd_idx2)        ? wb_data :
                                                           regs[rd_idx2];

endmodule

// File: rtl/id_stage_pipe.sv
// LEGv8 pipelined decode stage: register file, immediate extension and the
// ID/EX register. Define ID_HAZARD_STALL_EN to enable load-use bubbles.
module id_stage_pipe
   import legv8_pkg::*;
#(
   parameter int WORD      = 64,
   parameter int INST_SIZE = 32,
   parameter int NUM_REGS  = 32
) (
   input logic            clk,
   input logic            rst,
   id_stage_pipe_if.slave bus
);

   fmt_e            fmt;
   logic [4:0]      rn, rm, rd;
   logic [WORD-1:0] imm;
   logic [WORD-1:0] r_data1, r_data2;
   logic            hazard;
   logic            adv;

   logic            ex_valid_q;
   logic [WORD-1:0] ex_r_data1_q, ex_r_data2_q, ex_ex_data_q, ex_pc_q;
   logic [4:0]      ex_rd_q, ex_rn_q, ex_rm_q;
   fmt_e            ex_fmt_q;

   // NOTE: every signal written here gets a value on every path (defaults or
   // a full case) so no latch is inferred.
   always_comb begin
      fmt = classify(bus.if_inst[31:21]);
      rn  = bus.if_inst[9:5];
      rd  = bus.if_inst[4:0];
      rm  = (fmt == FMT_D_ST || fmt == FMT_CB) ? bus.if_inst[4:0] : bus.if_inst[20:16];
      case (fmt)
         FMT_B:              imm = {{(WORD-26){bus.if_inst[25]}}, bus.if_inst[25:0]};
         FMT_CB:             imm = {{(WORD-19){bus.if_inst[23]}}, bus.if_inst[23:5]};
         FMT_D_LD, FMT_D_ST: imm = {{(WORD-9){bus.if_inst[20]}}, bus.if_inst[20:12]};
         FMT_I:              imm = {{(WORD-12){1'b0}}, bus.if_inst[21:10]};
         default:            imm = {{(WORD-INST_SIZE){1'b0}}, bus.if_inst};
      endcase
   end

   id_regfile #(.WORD(WORD), .NUM_REGS(NUM_REGS)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .wb_en    (bus.wb_en),
      .wb_reg   (bus.wb_reg),
      .wb_data  (bus.wb_data),
      .rd_idx1  (rn),
      .rd_idx2  (rm),
      .rd_data1 (r_data1),
      .rd_data2 (r_data2)
   );

`ifdef ID_HAZARD_STALL_EN
   // Load in EX whose destination feeds a source the IF instruction reads.
   assign hazard = bus.if_valid && ex_valid_q && ex_fmt_q == FMT_D_LD &&
                   ex_rd_q != XZR_IDX &&
                   ((uses_rn(fmt) && rn == ex_rd_q) || (uses_rm(fmt) && rm == ex_rd_q));
`else
   assign hazard = 1'b0;
`endif

   assign adv = !ex_valid_q || bus.ex_ready;

   // A flush discards whatever IF offers, so IF may always move on.
   always_comb begin
      if (rst)            bus.id_ready = 1'b0;
      else if (bus.flush) bus.id_ready = 1'b1;
      else                bus.id_ready = adv && !hazard;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_r_data1_q <= '0;
         ex_r_data2_q <= '0;
         ex_ex_data_q <= '0;
         ex_pc_q      <= '0;
         ex_rd_q      <= '0;
         ex_rn_q      <= '0;
         ex_rm_q      <= '0;
         ex_fmt_q     <= FMT_R;
      end else if (bus.flush) begin
         ex_valid_q <= 1'b0;
      end else if (adv) begin
         if (hazard) begin
            ex_valid_q <= 1'b0;
         end else begin
            ex_valid_q   <= bus.if_valid;
            ex_r_data1_q <= r_data1;
            ex_r_data2_q <= r_data2;
            ex_ex_data_q <= imm;
            ex_pc_q      <= bus.if_pc;
            ex_rd_q      <= rd;
            ex_rn_q      <= rn;
            ex_rm_q      <= rm;
            ex_fmt_q     <= fmt;
         end
      end
   end

   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_r_data1 = ex_r_data1_q;
   assign bus.ex_r_data2 = ex_r_data2_q;
   assign bus.ex_ex_data = ex_ex_data_q;
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_rd      = ex_rd_q;
   assign bus.ex_rn      = ex_rn_q;
   assign bus.ex_rm      = ex_rm_q;
   assign bus.ex_fmt     = ex_fmt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed test-plan sequences followed by
// random traffic, checked against a behavioural decode/register model.
module tb_id_stage_pipe;
   import legv8_pkg::*;

`ifdef ID_HAZARD_STALL_EN
   localparam bit HAZARD_EN = 1'b1;
`else
   localparam bit HAZARD_EN = 1'b0;
`endif

   localparam logic [31:0] I_LDUR = 32'hF84402C9;  // LDUR X9,[X22,#64]
   localparam logic [31:0] I_ADD  = 32'h8B09026A;  // ADD X10,X19,X9
   localparam logic [31:0] I_CBZ  = 32'hB4FFFF6B;  // CBZ X11,-5
   localparam logic [31:0] I_B    = 32'h17FFFFC9;  // B -55
   localparam logic [31:0] I_XZR  = 32'h8B1F03E1;  // ADD X1,XZR,XZR

   typedef struct {
      logic [63:0] r1, r2, imm, pc;
      logic [4:0]  rd, rn, rm;
      fmt_e        fmt;
   } exp_t;

   logic tb_clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   logic [63:0] model_rf [32];

   id_stage_pipe_if bus ();

   id_stage_pipe dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural decode straight from the format and extension rules.
   function automatic exp_t decode(input logic [31:0] inst, input logic [63:0] pc);
      exp_t e;
      if (inst[31:26] == 6'h05)                              e.fmt = FMT_B;
      else if (inst[31:24] == 8'hB4 || inst[31:24] == 8'hB5) e.fmt = FMT_CB;
      else if (inst[31:21] == 11'h7C0)                       e.fmt = FMT_D_ST;
      else if (inst[31:21] == 11'h7C2)                       e.fmt = FMT_D_LD;
      else if (inst[31:22] == 10'h244 || inst[31:22] == 10'h344 ||
               inst[31:22] == 10'h248 || inst[31:22] == 10'h2C8) e.fmt = FMT_I;
      else                                                   e.fmt = FMT_R;
      case (e.fmt)
         FMT_B:              e.imm = 64'($signed(inst[25:0]));
         FMT_CB:             e.imm = 64'($signed(inst[23:5]));
         FMT_D_LD, FMT_D_ST: e.imm = 64'($signed(inst[20:12]));
         FMT_I:              e.imm = 64'(inst[21:10]);
         default:            e.imm = 64'(inst);
      endcase
      e.rd = inst[4:0];
      e.rn = inst[9:5];
      e.rm = (e.fmt == FMT_D_ST || e.fmt == FMT_CB) ? inst[4:0] : inst[20:16];
      e.pc = pc;
      e.r1 = '0;
      e.r2 = '0;
      return e;
   endfunction

   function automatic logic [63:0] rf_read(input logic [4:0] idx, input bit we,
                                           input logic [4:0] wr, input logic [63:0] wd);
      if (idx == 5'd31)          return '0;
      if (we && wr == idx)       return wd;
      return model_rf[idx];
   endfunction

   // One clock of stimulus: predict id_ready, then update the model at the edge.
   task automatic step(input bit r, input bit v, input logic [31:0] inst, input logic [63:0] pc,
                       input bit we, input logic [4:0] wr, input logic [63:0] wd,
                       input bit fl, input bit er);
      exp_t nx, cur;
      bit   ex_v, adv, haz, use_n, use_m, exp_ready;
      rst          = r;
      bus.if_valid = v;
      bus.if_inst  = inst;
      bus.if_pc    = pc;
      bus.wb_en    = we;
      bus.wb_reg   = wr;
      bus.wb_data  = wd;
      bus.flush    = fl;
      bus.ex_ready = er;
      @(negedge tb_clk);
      ex_v = (q.size() != 0);
      if (ex_v) cur = q[0];
      nx    = decode(inst, pc);
      nx.r1 = rf_read(nx.rn, we, wr, wd);
      nx.r2 = rf_read(nx.rm, we, wr, wd);
      use_n = (nx.fmt == FMT_R || nx.fmt == FMT_D_ST || nx.fmt == FMT_I || nx.fmt == FMT_D_LD);
      use_m = (nx.fmt == FMT_R || nx.fmt == FMT_D_ST || nx.fmt == FMT_CB);
      adv   = !ex_v || er;
      haz   = HAZARD_EN && v && ex_v && cur.fmt == FMT_D_LD && cur.rd != 5'd31 &&
              ((use_n && nx.rn == cur.rd) || (use_m && nx.rm == cur.rd));
      exp_ready = r ? 1'b0 : (fl ? 1'b1 : (adv && !haz));
      check("id_ready", 64'(bus.id_ready), 64'(exp_ready));
      @(posedge tb_clk);
      if (r) begin
         q.delete();
         for (int i = 0; i < 32; i++) model_rf[i] = '0;
      end else begin
         if (we && wr != 5'd31) model_rf[wr] = wd;
         if (fl && ex_v && !er) void'(q.pop_front());
         if (!fl && adv && !haz && v) q.push_back(nx);
      end
      #1;
   endtask

   task automatic idle(input bit er);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, er);
   endtask

   function automatic logic [4:0] pick_reg();
      return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(8, 11));
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] x;
      x       = $urandom;
      x[4:0]  = pick_reg();
      x[9:5]  = pick_reg();
      x[20:16] = pick_reg();
      case ($urandom_range(0, 5))
         0: x[31:26] = 6'h05;
         1: x[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
         2: x[31:21] = 11'h7C0;
         3: x[31:21] = 11'h7C2;
         4: case ($urandom_range(0, 3))
               0: x[31:22] = 10'h244;
               1: x[31:22] = 10'h344;
               2: x[31:22] = 10'h248;
               default: x[31:22] = 10'h2C8;
            endcase
         default: x[31:21] = 11'h458;
      endcase
      return x;
   endfunction

   // Monitor: compares whatever ID/EX presents against the scoreboard head
   // every cycle, and retires the head when EX takes it.
   initial begin
      bit xfer;
      forever begin
         @(negedge tb_clk);
         check("ex_valid", 64'(bus.ex_valid), 64'(q.size() != 0));
         if (q.size() != 0 && bus.ex_valid === 1'b1) begin
            check("ex_r_data1", bus.ex_r_data1, q[0].r1);
            check("ex_r_data2", bus.ex_r_data2, q[0].r2);
            check("ex_ex_data", bus.ex_ex_data, q[0].imm);
            check("ex_pc",      bus.ex_pc,      q[0].pc);
            check("ex_rd",      64'(bus.ex_rd), 64'(q[0].rd));
            check("ex_rn",      64'(bus.ex_rn), 64'(q[0].rn));
            check("ex_rm",      64'(bus.ex_rm), 64'(q[0].rm));
            check("ex_fmt",     64'(bus.ex_fmt), 64'(q[0].fmt));
         end
         xfer = (q.size() != 0) && bus.ex_ready && !rst;
         @(posedge tb_clk);
         if (xfer && q.size() != 0) void'(q.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
      bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
      bus.flush = 1'b0; bus.ex_ready = 1'b1;

      // Reset state.
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b1, 1'b1, I_ADD, 64'h40, 1'b0, '0, '0, 1'b0, 1'b1);
      check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
      check("rst_ex_data",  bus.ex_ex_data, 64'd0);
      check("rst_ex_rd",    64'(bus.ex_rd), 64'd0);

      // Load then dependent ADD; write-back of X9=1 lands in the accepting cycle.
      step(1'b0, 1'b1, I_LDUR, 64'h100, 1'b0, '0, '0, 1'b0, 1'b1);
      if (HAZARD_EN) begin
         step(1'b0, 1'b1, I_ADD, 64'h104, 1'b0, '0, '0, 1'b0, 1'b1);
         check("bubble_valid", 64'(bus.ex_valid), 64'd0);
      end
      step(1'b0, 1'b1, I_ADD, 64'h104, 1'b1, 5'd9, 64'd1, 1'b0, 1'b1);
      check("add_r_data2", bus.ex_r_data2, 64'd1);

      // Branch-format immediates.
      step(1'b0, 1'b1, I_CBZ, 64'h108, 1'b0, '0, '0, 1'b0, 1'b1);
      check("cbz_imm", bus.ex_ex_data, 64'hFFFF_FFFF_FFFF_FFFB);
      step(1'b0, 1'b1, I_B, 64'h10C, 1'b0, '0, '0, 1'b0, 1'b1);
      check("b_imm", bus.ex_ex_data, 64'hFFFF_FFFF_FFFF_FFC9);

      // XZR ignores writes.
      step(1'b0, 1'b0, '0, '0, 1'b1, 5'd31, 64'd5, 1'b0, 1'b1);
      step(1'b0, 1'b1, I_XZR, 64'h110, 1'b0, '0, '0, 1'b0, 1'b1);

      // Backpressure for three cycles.
      step(1'b0, 1'b1, I_ADD, 64'h114, 1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, I_CBZ, 64'h118, 1'b0, '0, '0, 1'b0, 1'b0);
      idle(1'b1);

      // Flush while a load-use hazard is pending.
      step(1'b0, 1'b1, I_LDUR, 64'h120, 1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, I_ADD, 64'h124, 1'b0, '0, '0, 1'b1, 1'b1);
      check("flush_valid", 64'(bus.ex_valid), 64'd0);
      idle(1'b1);

      // Reset mid-stream clears EX and the register file (X9 was 1).
      step(1'b0, 1'b1, I_LDUR, 64'h130, 1'b0, '0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b1, I_ADD, 64'h134, 1'b0, '0, '0, 1'b0, 1'b0);
      check("mid_rst_valid", 64'(bus.ex_valid), 64'd0);
      check("mid_rst_pc",    bus.ex_pc, 64'd0);
      step(1'b0, 1'b1, I_ADD, 64'h138, 1'b0, '0, '0, 1'b0, 1'b1);
      check("x9_after_rst", bus.ex_r_data2, 64'd0);
      idle(1'b1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0,
              rand_inst(),
              {$urandom, $urandom},
              $urandom_range(0, 1) != 0,
              pick_reg(),
              {$urandom, $urandom},
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) != 0);
      end
      idle(1'b1);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
